// File: rtl/operand_frame_loader.sv
// operand_frame_loader
// Collects four operand words plus a select bit from a valid/ready stream.
// Once the last word of a frame arrives, it commits all five values to the
// outputs together. The committed set is then held stable with ops_valid
// high for HOLD_CYCLES clocks. Staging registers are kept separate from the
// committed outputs, so a partial frame never disturbs what downstream sees.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | waiting for a frame-start word (in_first=1)
//  COLLECT | data_a staged; gathering words b, c, then d (d commits)
//  HOLD    | committed set presented with ops_valid; input stalled
module operand_frame_loader #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_c,
  output logic [WIDTH-1:0] data_d,
  output logic             sel,
  output logic             ops_valid,
  output logic             busy,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       idx;
  logic [3:0]       hold_cnt;
  logic [WIDTH-1:0] stage_a;
  logic [WIDTH-1:0] stage_b;
  logic [WIDTH-1:0] stage_c;

  logic xfer;
  logic load_first;
  logic load_mid;
  logic commit;
  logic err_nxt;

  assign in_ready = (state != HOLD);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and per-edge action strobes.
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_mid   = 1'b0;
    commit     = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (in_first) begin
            load_first = 1'b1;
            state_nxt  = COLLECT;
          end else begin
            // A word with no frame start is dropped.
            err_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (in_first) begin
            // Restart: the new word becomes data_a and the old partial frame is dropped.
            load_first = 1'b1;
            err_nxt    = 1'b1;
          end else if (idx == 2'd3) begin
            commit    = 1'b1;
            state_nxt = HOLD;
          end else begin
            load_mid = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Staging registers and word index within the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= 2'd0;
      stage_a <= '0;
      stage_b <= '0;
      stage_c <= '0;
    end else if (load_first) begin
      stage_a <= in_data;
      idx     <= 2'd1;
    end else if (load_mid) begin
      if (idx == 2'd1) stage_b <= in_data;
      else             stage_c <= in_data;
      idx <= idx + 2'd1;
    end else if (commit) begin
      idx <= 2'd0;
    end
  end

  // Committed outputs, the hold down-counter and ops_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_a    <= '0;
      data_b    <= '0;
      data_c    <= '0;
      data_d    <= '0;
      sel       <= 1'b0;
      ops_valid <= 1'b0;
      hold_cnt  <= 4'd0;
    end else if (commit) begin
      data_a    <= stage_a;
      data_b    <= stage_b;
      data_c    <= stage_c;
      data_d    <= in_data;
      sel       <= in_sel;
      ops_valid <= 1'b1;
      hold_cnt  <= HOLD_LOAD;
    end else if (state == HOLD) begin
      if (hold_cnt == 4'd0) ops_valid <= 1'b0;
      else                  hold_cnt  <= hold_cnt - 4'd1;
    end
  end

  // One-clock framing-error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_err <= 1'b0;
    else        frame_err <= err_nxt;
  end

endmodule
